// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage pipeline. It inserts a bubble on a load-use match,
// flushes younger stages on a taken branch in MEM, and freezes the pipe during slow memory accesses.
module pipeline_hazard_controller #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RegisterRs,
  input  logic [4:0]       ID_RegisterRt,
  input  logic             ID_UsesRt,
  input  logic [4:0]       EX_RegisterRt,
  input  logic             EX_MemRead,
  input  logic             MEM_BranchTaken,
  input  logic             MEM_MemAccess,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             MEM_WB_Flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(MAX_WAIT) + 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} stateT;

  stateT             state, stateNext;
  logic [WCNT_W-1:0] wcnt, wcntNext;
  logic              errSet;
  logic              freezeReq, loadUse;
  logic              doFreeze, doBranch, doStall;

  assign freezeReq = MEM_MemAccess && !mem_ready;
  assign loadUse   = EX_MemRead && (EX_RegisterRt != 5'd0) &&
                     ((EX_RegisterRt == ID_RegisterRs) ||
                      (ID_UsesRt && (EX_RegisterRt == ID_RegisterRt)));

  always_comb begin
    stateNext = state;
    wcntNext  = wcnt;
    errSet    = 1'b0;
    doFreeze  = 1'b0;
    doBranch  = 1'b0;
    doStall   = 1'b0;
    case (state)
      RUN: begin
        if (freezeReq) begin
          doFreeze  = 1'b1;
          stateNext = MEM_WAIT;
          wcntNext  = WCNT_W'(1);
        end else if (MEM_BranchTaken) begin
          doBranch = 1'b1;
        end else if (loadUse) begin
          doStall = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          doFreeze = 1'b1;
          if (wcnt == WCNT_W'(MAX_WAIT)) begin
            stateNext = ERROR;
            errSet    = 1'b1;
          end else begin
            wcntNext = wcnt + WCNT_W'(1);
          end
        end else begin
          // Release cycle: stages held their contents, so re-run the normal priority decode.
          stateNext = RUN;
          wcntNext  = '0;
          if (MEM_BranchTaken) doBranch = 1'b1;
          else if (loadUse)    doStall  = 1'b1;
        end
      end
      default: doFreeze = 1'b1;
    endcase
  end

  // Write enables and flushes are all forced low while reset is held.
  always_comb begin
    PC_Write     = rst_i && !doFreeze && !doStall;
    IF_ID_Write  = rst_i && !doFreeze && !doStall;
    ID_EX_Write  = rst_i && !doFreeze;
    EX_MEM_Write = rst_i && !doFreeze;
    IF_ID_Flush  = rst_i && doBranch;
    ID_EX_Flush  = rst_i && (doBranch || doStall);
    EX_MEM_Flush = rst_i && doBranch;
    MEM_WB_Flush = rst_i && doFreeze;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      wcnt      <= '0;
      mem_error <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= stateNext;
      wcnt  <= wcntNext;
      if (errSet) mem_error <= 1'b1;
      if (!PC_Write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (doBranch && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
